// File: rtl/im_loader.sv
//==============================================================================
// Module   : im_loader
// Purpose  : Boot-time programming controller for the instruction memory.
//            Takes a byte stream from the host link: a 16-bit big-endian
//            word count followed by that many 32-bit big-endian words. It
//            then issues one write cycle per word on the instruction-memory
//            write port. The CPU pipeline is held stalled while a load runs.
// Ports    : clk, rst            - clock (rising edge), async active-high reset
//            start               - pulse that begins a load (IDLE or ERR only)
//            rx_data/rx_valid    - host byte and its valid qualifier
//            rx_ready            - controller accepts a byte this cycle
//            im_add/im_data      - write word index (zero-extended) and word
//            im_en/im_rd_wr      - write strobe pair, high only in WRITE
//            cpu_stall/busy      - high whenever the controller is not IDLE
//            done                - one-cycle pulse on successful completion
//            err                 - held while in the error state
//            words_loaded        - words written in the current/last load
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module im_loader #(
    parameter int DEPTH   = 128,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [31:0]      im_add,
    output logic [31:0]      im_data,
    output logic             im_en,
    output logic             im_rd_wr,
    output logic             cpu_stall,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] words_loaded
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_BYTE   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    logic [2:0]       state_q,  state_d;
    logic [15:0]      len_q,    len_d;
    logic [31:0]      data_q,   data_d;
    logic [1:0]       bidx_q,   bidx_d;
    logic [CNT_W-1:0] widx_q,   widx_d;
    logic [CNT_W-1:0] wcnt_q,   wcnt_d;
    logic [TMO_W-1:0] tmo_q,    tmo_d;

    logic             w_rx_open;
    logic             w_hs;
    logic [15:0]      w_len;
    logic [CNT_W-1:0] w_wcnt_inc;
    logic             w_last;

    // Byte acceptance depends on state only, so rx_ready never loops back
    // through rx_valid.
    assign w_rx_open  = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_BYTE);
    assign w_hs       = w_rx_open && rx_valid;
    assign w_len      = {len_q[15:8], rx_data};
    assign w_wcnt_inc = wcnt_q + CNT_W'(1);
    assign w_last     = ({{(16-CNT_W){1'b0}}, w_wcnt_inc} == len_q);

    //--------------------------------------------------------------------------
    // State and datapath registers
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            data_q  <= '0;
            bidx_q  <= '0;
            widx_q  <= '0;
            wcnt_q  <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            data_q  <= data_d;
            bidx_q  <= bidx_d;
            widx_q  <= widx_d;
            wcnt_q  <= wcnt_d;
            tmo_q   <= tmo_d;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        data_d  = data_q;
        bidx_d  = bidx_q;
        widx_d  = widx_q;
        wcnt_d  = wcnt_q;
        tmo_d   = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    wcnt_d  = '0;
                    widx_d  = '0;
                end
            end
            S_LEN_HI: begin
                if (w_hs) begin
                    len_d[15:8] = rx_data;
                    state_d     = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (w_hs) begin
                    len_d = w_len;
                    if (w_len == 16'd0) begin
                        state_d = S_DONE;
                    end else if (w_len > 16'(DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_BYTE;
                        bidx_d  = 2'd0;
                    end
                end
            end
            S_BYTE: begin
                if (w_hs) begin
                    case (bidx_q)
                        2'd0:    data_d[31:24] = rx_data;
                        2'd1:    data_d[23:16] = rx_data;
                        2'd2:    data_d[15:8]  = rx_data;
                        default: data_d[7:0]   = rx_data;
                    endcase
                    bidx_d = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                wcnt_d = w_wcnt_inc;
                if (w_last) begin
                    // Index is left on the last word so it never reaches DEPTH.
                    state_d = S_DONE;
                end else begin
                    widx_d  = widx_q + CNT_W'(1);
                    state_d = S_BYTE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                if (start) begin
                    state_d = S_LEN_HI;
                    wcnt_d  = '0;
                    widx_d  = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Idle watchdog on the receive states. A handshake always wins over
        // an expiring count; a partial word is simply abandoned.
        if (w_rx_open) begin
            if (w_hs) begin
                tmo_d = '0;
            end else if (tmo_q >= TMO_W'(TIMEOUT - 1)) begin
                state_d = S_ERR;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end

        if (state_d != state_q) begin
            tmo_d = '0;
        end
    end

    //--------------------------------------------------------------------------
    // Output logic (decoded from registered state only)
    //--------------------------------------------------------------------------
    always_comb begin
        rx_ready     = w_rx_open;
        im_en        = (state_q == S_WRITE);
        im_rd_wr     = (state_q == S_WRITE);
        cpu_stall    = (state_q != S_IDLE);
        busy         = (state_q != S_IDLE);
        done         = (state_q == S_DONE);
        err          = (state_q == S_ERR);
        im_add       = {{(32-CNT_W){1'b0}}, widx_q};
        im_data      = data_q;
        words_loaded = wcnt_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_im_loader.sv
//==============================================================================
// Module   : tb_im_loader
// Purpose  : Self-checking bench for im_loader. A cycle table covers the
//            streaming two-word load, a zero-length load and an oversize
//            length; hand-written sequences cover the idle timeout, an
//            asynchronous reset mid-word and a full 128-word load with gaps.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_im_loader;

    localparam int DEPTH   = 128;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [31:0]      im_add;
    logic [31:0]      im_data;
    logic             im_en;
    logic             im_rd_wr;
    logic             cpu_stall;
    logic             busy;
    logic             done;
    logic             err;
    logic [CNT_W-1:0] words_loaded;

    im_loader #(
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .im_add       (im_add),
        .im_data      (im_data),
        .im_en        (im_en),
        .im_rd_wr     (im_rd_wr),
        .cpu_stall    (cpu_stall),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Write log: one entry per cycle with im_en high.
    logic [31:0] wr_add[$];
    logic [31:0] wr_dat[$];
    always @(negedge clk) begin
        if (im_en === 1'b1) begin
            wr_add.push_back(im_add);
            wr_dat.push_back(im_data);
        end
    end

    // One row per cycle: inputs driven for the coming edge, and the outputs
    // expected from the current state. wl < 0 means words_loaded unchecked.
    typedef struct {
        bit          st;
        bit          v;
        logic [7:0]  d;
        bit          rdy;
        bit          en;
        logic [31:0] add;
        logic [31:0] dat;
        bit          dn;
        bit          stl;
        bit          er;
        int          wl;
    } vec_t;

    vec_t vecs[$];

    function automatic void addv(input bit st, input bit v, input logic [7:0] d,
                                 input bit rdy, input bit en, input logic [31:0] add,
                                 input logic [31:0] dat, input bit dn, input bit stl,
                                 input bit er, input int wl);
        vec_t t;
        t.st = st; t.v = v; t.d = d; t.rdy = rdy; t.en = en; t.add = add;
        t.dat = dat; t.dn = dn; t.stl = stl; t.er = er; t.wl = wl;
        vecs.push_back(t);
    endfunction

    function automatic logic [31:0] wword(input int w);
        logic [7:0] k;
        k = w[7:0];
        return {k, ~k, k ^ 8'h5A, k + 8'h3C};
    endfunction

    // Present a byte until it is accepted (bounded).
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = b;
            #1;
            if (rx_ready === 1'b1) break;
            n++;
            if (n > 20) begin
                checks++;
                errors++;
                $display("FAIL handshake: rx_ready stayed %b, expected 1", rx_ready);
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tmp;
        int          nwr;
        bit          seen;

        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;

        // ---------------- reset state ----------------
        @(negedge clk);
        check("reset rx_ready",  {31'd0, rx_ready},  32'd0);
        check("reset im_en",     {31'd0, im_en},     32'd0);
        check("reset im_rd_wr",  {31'd0, im_rd_wr},  32'd0);
        check("reset cpu_stall", {31'd0, cpu_stall}, 32'd0);
        check("reset busy",      {31'd0, busy},      32'd0);
        check("reset done",      {31'd0, done},      32'd0);
        check("reset err",       {31'd0, err},       32'd0);
        check("reset im_add",    im_add,             32'd0);
        check("reset im_data",   im_data,            32'd0);
        check("reset words",     {24'd0, words_loaded}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ---------------- cycle table ----------------
        // two-word streaming load
        addv(1, 0, 8'h00, 0, 0, 0, 0,            0, 0, 0, 0);
        addv(0, 1, 8'h00, 1, 0, 0, 0,            0, 1, 0, 0);
        addv(0, 1, 8'h02, 1, 0, 0, 0,            0, 1, 0, 0);
        addv(0, 1, 8'hDE, 1, 0, 0, 0,            0, 1, 0, 0);
        addv(0, 1, 8'hAD, 1, 0, 0, 0,            0, 1, 0, 0);
        addv(0, 1, 8'hBE, 1, 0, 0, 0,            0, 1, 0, 0);
        addv(0, 1, 8'hEF, 1, 0, 0, 0,            0, 1, 0, 0);
        addv(0, 1, 8'h01, 0, 1, 0, 32'hDEADBEEF, 0, 1, 0, 0);
        addv(0, 1, 8'h01, 1, 0, 0, 0,            0, 1, 0, 1);
        addv(0, 1, 8'h23, 1, 0, 0, 0,            0, 1, 0, 1);
        addv(0, 1, 8'h45, 1, 0, 0, 0,            0, 1, 0, 1);
        addv(0, 1, 8'h67, 1, 0, 0, 0,            0, 1, 0, 1);
        addv(0, 0, 8'h00, 0, 1, 1, 32'h01234567, 0, 1, 0, 1);
        addv(0, 0, 8'h00, 0, 0, 0, 0,            1, 1, 0, 2);
        addv(0, 0, 8'h00, 0, 0, 0, 0,            0, 0, 0, -1);
        // zero length
        addv(1, 0, 8'h00, 0, 0, 0, 0,            0, 0, 0, -1);
        addv(0, 1, 8'h00, 1, 0, 0, 0,            0, 1, 0, 0);
        addv(0, 1, 8'h00, 1, 0, 0, 0,            0, 1, 0, 0);
        addv(0, 0, 8'h00, 0, 0, 0, 0,            1, 1, 0, 0);
        addv(0, 0, 8'h00, 0, 0, 0, 0,            0, 0, 0, -1);
        // oversize length 129, then restart from ERR
        addv(1, 0, 8'h00, 0, 0, 0, 0,            0, 0, 0, -1);
        addv(0, 1, 8'h00, 1, 0, 0, 0,            0, 1, 0, 0);
        addv(0, 1, 8'h81, 1, 0, 0, 0,            0, 1, 0, 0);
        addv(0, 1, 8'h55, 0, 0, 0, 0,            0, 1, 1, -1);
        addv(0, 1, 8'h55, 0, 0, 0, 0,            0, 1, 1, -1);
        addv(1, 0, 8'h00, 0, 0, 0, 0,            0, 1, 1, -1);
        addv(0, 1, 8'h00, 1, 0, 0, 0,            0, 1, 0, 0);
        addv(0, 1, 8'h00, 1, 0, 0, 0,            0, 1, 0, 0);
        addv(0, 0, 8'h00, 0, 0, 0, 0,            1, 1, 0, 0);
        addv(0, 0, 8'h00, 0, 0, 0, 0,            0, 0, 0, -1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            start    = vecs[i].st;
            rx_valid = vecs[i].v;
            rx_data  = vecs[i].d;
            #1;
            check($sformatf("v%0d rx_ready", i),  {31'd0, rx_ready},  {31'd0, vecs[i].rdy});
            check($sformatf("v%0d im_en", i),     {31'd0, im_en},     {31'd0, vecs[i].en});
            check($sformatf("v%0d im_rd_wr", i),  {31'd0, im_rd_wr},  {31'd0, vecs[i].en});
            check($sformatf("v%0d done", i),      {31'd0, done},      {31'd0, vecs[i].dn});
            check($sformatf("v%0d cpu_stall", i), {31'd0, cpu_stall}, {31'd0, vecs[i].stl});
            check($sformatf("v%0d busy", i),      {31'd0, busy},      {31'd0, vecs[i].stl});
            check($sformatf("v%0d err", i),       {31'd0, err},       {31'd0, vecs[i].er});
            if (vecs[i].en) begin
                check($sformatf("v%0d im_add", i),  im_add,  vecs[i].add);
                check($sformatf("v%0d im_data", i), im_data, vecs[i].dat);
            end
            if (vecs[i].wl >= 0) begin
                check($sformatf("v%0d words", i), {24'd0, words_loaded}, vecs[i].wl);
            end
        end
        start = 1'b0;
        rx_valid = 1'b0;

        // ---------------- timeout mid-word ----------------
        nwr = wr_add.size();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        @(negedge clk); rx_valid = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        check("timeout early err", {31'd0, err}, 32'd0);
        repeat (10) @(negedge clk);
        #1;
        check("timeout err",       {31'd0, err},       32'd1);
        check("timeout stall",     {31'd0, cpu_stall}, 32'd1);
        check("timeout rx_ready",  {31'd0, rx_ready},  32'd0);
        check("timeout no write",  wr_add.size(),      nwr);

        // ---------------- async reset mid-word ----------------
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clk); rx_valid = 1'b0;
        #1;
        check("pre-reset rx_ready", {31'd0, rx_ready}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst rx_ready",  {31'd0, rx_ready},  32'd0);
        check("arst cpu_stall", {31'd0, cpu_stall}, 32'd0);
        check("arst busy",      {31'd0, busy},      32'd0);
        check("arst err",       {31'd0, err},       32'd0);
        check("arst im_data",   im_data,            32'd0);
        check("arst words",     {24'd0, words_loaded}, 32'd0);
        nwr = wr_add.size();
        @(negedge clk); rst = 1'b0;
        rx_valid = 1'b1; rx_data = 8'hCC;
        repeat (6) @(negedge clk);
        #1;
        check("post-reset rx_ready", {31'd0, rx_ready},  32'd0);
        check("post-reset stall",    {31'd0, cpu_stall}, 32'd0);
        check("post-reset no write", wr_add.size(),      nwr);
        rx_valid = 1'b0;

        // ---------------- 128-word load with gaps ----------------
        wr_add.delete();
        wr_dat.delete();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        send_byte(8'h00);
        send_byte(8'h80);
        for (int w = 0; w < DEPTH; w++) begin
            tmp = wword(w);
            for (int b = 0; b < 4; b++) begin
                if (w == 50 && b == 1) begin
                    @(negedge clk); rx_valid = 1'b0; start = 1'b1;
                    @(negedge clk); start = 1'b0;
                end
                repeat ($urandom_range(0, 2)) begin
                    @(negedge clk); rx_valid = 1'b0;
                end
                send_byte(tmp[31 - 8*b -: 8]);
            end
        end
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk); rx_valid = 1'b0;
            #1;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("gap done seen", {31'd0, seen},         32'd1);
        check("gap words",     {24'd0, words_loaded}, 32'd128);
        check("gap err",       {31'd0, err},          32'd0);
        @(negedge clk);
        #1;
        check("gap stall released", {31'd0, cpu_stall}, 32'd0);
        check("gap write count",    wr_add.size(),      32'd128);
        for (int w = 0; w < DEPTH && w < wr_add.size(); w++) begin
            check($sformatf("gap add %0d", w),  wr_add[w], w);
            check($sformatf("gap data %0d", w), wr_dat[w], wword(w));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
